// File: rtl/byte_serial_addsub.sv
// Byte-serial multi-byte add/subtract sequencer: one shared 8-bit ripple-carry
// adder processes an NBYTES-wide operation LSB byte first, one byte per clock.

module adder8bit (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]  = in1[i] ^ in2[i] ^ c[i];
        assign c[i+1]  = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end

    assign cout = c[8];
endmodule

module byte_serial_addsub #(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                op,
    input  logic [8*NBYTES-1:0] opA,
    input  logic [8*NBYTES-1:0] opB,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                overflow
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            op_q, op_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [IW+2:0]   base;
    logic [7:0]      in1, in2, sum;
    logic            add_cout;

    // Byte lane offset for the current index (index * 8).
    assign base = {idx_q, 3'b000};
    assign in1  = a_q[base +: 8];
    assign in2  = op_q ? ~b_q[base +: 8] : b_q[base +: 8];

    adder8bit u_adder (
        .in1  (in1),
        .in2  (in2),
        .cin  (carry_q),
        .sum  (sum),
        .cout (add_cout)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case statement leaves it unassigned (which would infer a latch).
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = opA;
                    b_d     = opB;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = op;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[base +: 8] = sum;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NBYTES - 1)) begin
                    cout_d  = add_cout;
                    ovf_d   = (in1[7] == in2[7]) && (sum[7] != in1[7]);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule
